// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round constants, FSM encoding, byte and column helpers.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    // Round constant applied while computing round r; r outside 1..10 is unused.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Byte i of a 128-bit state; byte 0 sits in the low bits.
    function automatic logic [7:0] get_byte(input logic [127:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, row r in bits [8r+7:8r].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        return {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] t;
        for (int c = 0; c < 4; c++) begin
            t[32*c +: 32] = mix_column(s[32*c +: 32]);
        end
        return t;
    endfunction

    // Column-major state: byte index = row + 4*col; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[8*(r + 4*c) +: 8] = get_byte(s, r + 4*((c + r) % 4));
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure lookup.
// Latency: combinational.
// Backpressure: n/a.
// Ports: in_i - byte to substitute; out_o - substituted byte.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Row 0 is written first, so entry 0 lands at the top index: look up with ~in_i.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[~in_i];

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor, one round per clock, round keys expanded on the fly.
// Latency: accept -> done = 10 cycles; back-to-back period 11 with read_en held high.
// Backpressure: none; read_en is only sampled in IDLE, requests while busy are dropped.
// Ports: clk/rst (sync, active-high); data/key in (byte 0 = bits [7:0]); read_en start level;
//        out_data ciphertext held until next completion; done one-cycle pulse;
//        state/key_test debug (round counter, last applied round key), zero when DBG_EN=0.
module aes_encrypt
    import aes_pkg::*;
#(
    parameter int NR     = NR_AES128,   // only 10 is meaningful
    parameter bit DBG_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data,
    input  logic [127:0] key,
    input  logic         read_en,
    output logic [127:0] out_data,
    output logic         done,
    output logic [3:0]   state,
    output logic [127:0] key_test
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] out_q, out_d;
    logic [127:0] kt_q, kt_d;
    logic         done_q, done_d;

    logic [31:0]  rot_w, sub_w, w0, w1, w2, w3;
    logic [127:0] rk_next, sb_st, rnd_val;
    logic         last_round;

    // Key schedule: RotWord of the top word (byte 12 moves to the top byte).
    assign rot_w = {rk_q[103:96], rk_q[127:104]};

    for (genvar i = 0; i < 4; i++) begin : g_ks_sbox
        aes_sbox u_sbox (.in_i(rot_w[8*i +: 8]), .out_o(sub_w[8*i +: 8]));
    end

    assign w0      = rk_q[31:0]   ^ sub_w ^ {24'd0, rcon(round_q)};
    assign w1      = rk_q[63:32]  ^ w0;
    assign w2      = rk_q[95:64]  ^ w1;
    assign w3      = rk_q[127:96] ^ w2;
    assign rk_next = {w3, w2, w1, w0};

    for (genvar i = 0; i < 16; i++) begin : g_dp_sbox
        aes_sbox u_sbox (.in_i(st_q[8*i +: 8]), .out_o(sb_st[8*i +: 8]));
    end

    assign last_round = (round_q == LAST_ROUND);
    assign rnd_val    = (last_round ? shift_rows(sb_st) : mix_columns(shift_rows(sb_st))) ^ rk_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            round_q <= '0;
            st_q    <= '0;
            rk_q    <= '0;
            out_q   <= '0;
            kt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            out_q   <= out_d;
            kt_q    <= kt_d;
            done_q  <= done_d;
        end
    end

    // Next state
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (read_en)    fsm_d = ST_RUN;
            ST_RUN:  if (last_round) fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Datapath / outputs
    always_comb begin
        round_d = round_q;
        st_d    = st_q;
        rk_d    = rk_q;
        out_d   = out_q;
        kt_d    = kt_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (read_en) begin
                    st_d    = data ^ key;
                    rk_d    = key;
                    kt_d    = key;
                    round_d = 4'd1;
                end
            end
            ST_RUN: begin
                st_d = rnd_val;
                rk_d = rk_next;
                kt_d = rk_next;
                if (last_round) begin
                    out_d   = rnd_val;
                    done_d  = 1'b1;
                    round_d = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign out_data = out_q;
    assign done     = done_q;
    assign state    = DBG_EN ? round_q : 4'd0;
    assign key_test = DBG_EN ? kt_q : 128'd0;

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt: whole-cipher reference model (S-box derived from
// GF(2^8) inversion), cycle-by-cycle output comparison, directed FIPS vectors, random traffic.
module tb_aes_encrypt;

    localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] C1_RK1 = 128'hfe76abd6f178a6dafa72afd2fd74aad6;
    localparam logic [127:0] C1_RK10 = 128'hc5302b4d8ba707f3174a94e37f1d1113;
    localparam logic [127:0] ZERO_CT = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data, key;
    logic         read_en;
    logic [127:0] out_data;
    logic         done;
    logic [3:0]   state;
    logic [127:0] key_test;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [7:0] sb [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    aes_encrypt #(.NR(10), .DBG_EN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .key      (key),
        .read_en  (read_en),
        .out_data (out_data),
        .done     (done),
        .state    (state),
        .key_test (key_test)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from the definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv, t, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        s = inv;
        t = inv;
        for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [7:0]   w [176];
        logic [7:0]   t [4];
        logic [7:0]   rc, tmp;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) w[i] = k[8*i +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[tmp];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = w[16*r + i];
        return res;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        rk = round_key(k, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[8*i +: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            rk = round_key(k, rnd);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*c] = sb[s[r + 4*((c + r) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd < 10)
                        s[r + 4*c] = gmul(8'd2, t[r + 4*c]) ^ gmul(8'd3, t[(r+1)%4 + 4*c])
                                   ^ t[(r+2)%4 + 4*c] ^ t[(r+3)%4 + 4*c];
                    else
                        s[r + 4*c] = t[r + 4*c];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[8*i +: 8];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        rk = round_key(k, 10);
        for (int i = 0; i < 16; i++) s[i] = ct[8*i +: 8] ^ rk[8*i +: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r + 4*((c + r) % 4)] = isb[s[r + 4*c]];
            rk = round_key(k, rnd);
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ rk[8*i +: 8];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd > 0)
                        s[r + 4*c] = gmul(8'd14, t[r + 4*c]) ^ gmul(8'd11, t[(r+1)%4 + 4*c])
                                   ^ gmul(8'd13, t[(r+2)%4 + 4*c]) ^ gmul(8'd9, t[(r+3)%4 + 4*c]);
                    else
                        s[r + 4*c] = t[r + 4*c];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // ---------------- cycle timing model ----------------
    logic         m_busy = 1'b0;
    logic [3:0]   m_round = 4'd0;
    logic [127:0] m_key = '0, m_ct = '0, m_out = '0, m_kt = '0;
    logic         m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_round = 4'd0; m_out = '0; m_kt = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (read_en === 1'b1) begin
                    m_busy  = 1'b1;
                    m_key   = key;
                    m_ct    = aes_enc(data, key);
                    m_round = 4'd1;
                    m_kt    = key;
                end
            end else begin
                m_kt = round_key(m_key, int'(m_round));
                if (m_round == 4'd10) begin
                    m_out = m_ct; m_done = 1'b1; m_round = 4'd0; m_busy = 1'b0;
                end else begin
                    m_round = m_round + 4'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_done",     128'(done),  128'(m_done));
            chk("cyc_state",    128'(state), 128'(m_round));
            chk("cyc_out_data", out_data,    m_out);
            chk("cyc_key_test", key_test,    m_kt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [127:0] d, input logic [127:0] k);
        @(negedge clk);
        data = d; key = k; read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    // Called right after start_op; latency is counted in cycles from the accept edge.
    task automatic wait_done(output logic [127:0] got, output int lat, output logic [127:0] kt2);
        got = '0; lat = 0; kt2 = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (state == 4'd2) kt2 = key_test;
            if (done) begin
                got = out_data; lat = i;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] got, kt2, d, k;
        int lat, pulses, last_i, late_done;

        for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

        // Pin the model to published vectors.
        chk("model_c1_ct",   aes_enc(C1_PT, C1_KEY), C1_CT);
        chk("model_zero_ct", aes_enc('0, '0), ZERO_CT);
        chk("model_rk1",     round_key(C1_KEY, 1), C1_RK1);
        chk("model_rk10",    round_key(C1_KEY, 10), C1_RK10);
        chk("model_dec",     aes_dec(C1_CT, C1_KEY), C1_PT);

        rst = 1'b1; read_en = 1'b0; data = '0; key = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_out_data", out_data, '0);
        chk("rst_done",     128'(done), 128'(0));
        chk("rst_state",    128'(state), 128'(0));
        chk("rst_key_test", key_test, '0);

        // FIPS-197 C.1 with key schedule probes.
        start_op(C1_PT, C1_KEY);
        wait_done(got, lat, kt2);
        chk("c1_latency", 128'(lat), 128'(10));
        chk("c1_out",     got, C1_CT);
        chk("c1_rk1",     kt2, C1_RK1);
        chk("c1_rk10",    key_test, C1_RK10);
        chk("c1_roundtrip", aes_dec(got, C1_KEY), C1_PT);

        start_op('0, '0);
        wait_done(got, lat, kt2);
        chk("zero_out", got, ZERO_CT);

        // read_en held high: one-cycle done every 11 cycles.
        @(negedge clk);
        data = C1_PT; key = C1_KEY; read_en = 1'b1;
        pulses = 0; last_i = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (last_i != 0) chk("held_gap", 128'(i - last_i), 128'(11));
                last_i = i;
                chk("held_out", out_data, C1_CT);
            end
        end
        read_en = 1'b0;
        chk("held_pulses", 128'(pulses), 128'(3));
        repeat (12) @(negedge clk);

        // Inputs changed mid-operation must not matter.
        d = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        start_op(d, k);
        repeat (4) @(negedge clk);
        data = ~d; key = {$urandom, $urandom, $urandom, $urandom};
        wait_done(got, lat, kt2);
        chk("midchange_latency", 128'(lat), 128'(6));
        chk("midchange_out", got, aes_enc(d, k));

        // Reset at round 5 aborts cleanly.
        start_op(C1_PT, C1_KEY);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", 128'(state), 128'(0));
        chk("abort_out",   out_data, '0);
        chk("abort_done",  128'(done), 128'(0));
        late_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("abort_no_done", 128'(late_done), 128'(0));
        start_op(C1_PT, C1_KEY);
        wait_done(got, lat, kt2);
        chk("after_abort_out", got, C1_CT);

        // Reset and read_en together: reset wins.
        @(negedge clk);
        rst = 1'b1; read_en = 1'b1; data = C1_PT; key = C1_KEY;
        @(negedge clk);
        rst = 1'b0; read_en = 1'b0;
        chk("rst_wins_state", 128'(state), 128'(0));
        repeat (12) @(negedge clk);

        // Random operations with round-trip check.
        for (int n = 0; n < 8; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            start_op(d, k);
            wait_done(got, lat, kt2);
            chk("rand_latency",   128'(lat), 128'(10));
            chk("rand_roundtrip", aes_dec(got, k), d);
        end

        // Free-running random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            read_en = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            data    = {$urandom, $urandom, $urandom, $urandom};
            key     = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        rst = 1'b0; read_en = 1'b0;
        repeat (14) @(negedge clk);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
